// File: rtl/btn_conditioner.sv
`default_nettype none
// btn_conditioner: per-button 2-flop synchroniser, debouncer and press pulse. Rev 1.0
// Optional macro BTN_AUTOREPEAT_EN adds auto-repeat pulses while a button stays held.
module btn_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      logic          s1;
      logic          s2;
      logic [CW-1:0] cnt;
      logic          level_r;
      logic          pulse_r;
      logic          accept;
      logic          level_next;
      logic          repeat_fire;

      always_comb begin
        accept     = (s2 != level_r) && (cnt == CNT_LAST);
        level_next = accept ? s2 : level_r;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1      <= 1'b0;
          s2      <= 1'b0;
          cnt     <= '0;
          level_r <= 1'b0;
        end else begin
          s1      <= btn_raw[i];
          s2      <= s1;
          level_r <= level_next;
          if (s2 == level_r || accept)
            cnt <= '0;
          else
            cnt <= cnt + 1'b1;
        end
      end

`ifdef BTN_AUTOREPEAT_EN
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = $clog2(RMAX + 1);
      logic [RW-1:0] rcnt;

      // Down-counter loaded on the press edge; hitting zero while held fires a repeat.
      always_ff @(posedge clk) begin
        if (rst || !level_next)
          rcnt <= '0;
        else if (!level_r)
          rcnt <= RW'(REPEAT_DELAY - 1);
        else if (rcnt == '0)
          rcnt <= RW'(REPEAT_PERIOD - 1);
        else
          rcnt <= rcnt - 1'b1;
      end

      assign repeat_fire = level_r && level_next && (rcnt == '0);
`else
      assign repeat_fire = 1'b0;
`endif

      always_ff @(posedge clk) begin
        if (rst)
          pulse_r <= 1'b0;
        else
          pulse_r <= (level_next && !level_r) || repeat_fire;
      end

      assign btn_level[i] = level_r;
      assign btn_pulse[i] = pulse_r;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// tb_btn_conditioner: scoreboard bench, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_btn_conditioner;

  localparam int N = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] pul;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  btn_conditioner #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  // Held buttons through reset: outputs zero during reset, rise 6 edges after release.
  task automatic test_reset();
    exp_t e;
    rst     = 1'b1;
    btn_raw = 3'b111;
    for (int n = 0; n < 2; n++) begin
      e.lvl = 3'b000;
      e.pul = 3'b000;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (btn_level !== e.lvl || btn_pulse !== e.pul) begin
        errors++;
        $display("FAIL reset_hold n=%0d level=%b pulse=%b expected level=%b pulse=%b",
                 n, btn_level, btn_pulse, e.lvl, e.pul);
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      btn_raw = (n < 7) ? 3'b111 : 3'b000;
      e.lvl = (n >= 6 && n < 12) ? 3'b111 : 3'b000;
      e.pul = (n == 6) ? 3'b111 : 3'b000;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (btn_level !== e.lvl || btn_pulse !== e.pul) begin
        errors++;
        $display("FAIL reset_release n=%0d level=%b pulse=%b expected level=%b pulse=%b",
                 n, btn_level, btn_pulse, e.lvl, e.pul);
      end
    end
  endtask

  // Channel 0 pressed at edge 0, held 20 samples, then released.
  task automatic test_press_release();
    exp_t e;
    for (int n = 0; n < 30; n++) begin
      btn_raw = (n < 20) ? 3'b001 : 3'b000;
      e.lvl = (n >= 5 && n < 25) ? 3'b001 : 3'b000;
      e.pul = (n == 5 || (AR && n >= 13 && n < 25 && (n - 13) % 3 == 0)) ? 3'b001 : 3'b000;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (btn_level !== e.lvl || btn_pulse !== e.pul) begin
        errors++;
        $display("FAIL press_release n=%0d level=%b pulse=%b expected level=%b pulse=%b",
                 n, btn_level, btn_pulse, e.lvl, e.pul);
      end
    end
  endtask

  // Three-sample high glitch on channel 1 must be rejected.
  task automatic test_glitch();
    exp_t e;
    for (int n = 0; n < 12; n++) begin
      btn_raw = (n < 3) ? 3'b010 : 3'b000;
      e.lvl = 3'b000;
      e.pul = 3'b000;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (btn_level !== e.lvl || btn_pulse !== e.pul) begin
        errors++;
        $display("FAIL glitch n=%0d level=%b pulse=%b expected level=%b pulse=%b",
                 n, btn_level, btn_pulse, e.lvl, e.pul);
      end
    end
  endtask

  // Chatter 1,0,1,1,... on channel 2: count restarts after the 0 sample.
  task automatic test_chatter();
    exp_t e;
    for (int n = 0; n < 20; n++) begin
      btn_raw = (n == 1 || n >= 12) ? 3'b000 : 3'b100;
      e.lvl = (n >= 7 && n < 17) ? 3'b100 : 3'b000;
      e.pul = (n == 7 || (AR && n == 15)) ? 3'b100 : 3'b000;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (btn_level !== e.lvl || btn_pulse !== e.pul) begin
        errors++;
        $display("FAIL chatter n=%0d level=%b pulse=%b expected level=%b pulse=%b",
                 n, btn_level, btn_pulse, e.lvl, e.pul);
      end
    end
  endtask

  // All three channels pressed together give simultaneous pulses.
  task automatic test_simultaneous();
    exp_t e;
    for (int n = 0; n < 18; n++) begin
      btn_raw = (n < 10) ? 3'b111 : 3'b000;
      e.lvl = (n >= 5 && n < 15) ? 3'b111 : 3'b000;
      e.pul = (n == 5 || (AR && n == 13)) ? 3'b111 : 3'b000;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (btn_level !== e.lvl || btn_pulse !== e.pul) begin
        errors++;
        $display("FAIL simultaneous n=%0d level=%b pulse=%b expected level=%b pulse=%b",
                 n, btn_level, btn_pulse, e.lvl, e.pul);
      end
    end
  endtask

  // Reset at edge 4 (count=2) discards progress; a full debounce restarts after it.
  task automatic test_reset_mid();
    exp_t e;
    for (int n = 0; n < 22; n++) begin
      rst     = (n == 4);
      btn_raw = (n < 14) ? 3'b001 : 3'b000;
      e.lvl = (n >= 10 && n < 19) ? 3'b001 : 3'b000;
      e.pul = (n == 10 || (AR && n == 18)) ? 3'b001 : 3'b000;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (btn_level !== e.lvl || btn_pulse !== e.pul) begin
        errors++;
        $display("FAIL reset_mid n=%0d level=%b pulse=%b expected level=%b pulse=%b",
                 n, btn_level, btn_pulse, e.lvl, e.pul);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = 3'b000;
    test_reset();
    test_press_release();
    test_glitch();
    test_chatter();
    test_simultaneous();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end conditioning stage for the board push-buttons. Sits directly upstream of the operand-capture/multiply/compare logic and drives its btn load-enable inputs.
- Synchronises each raw button, debounces it, and emits a clean debounced level plus a single-cycle press pulse, so each press loads an operand exactly once.
- One independent channel per button; there is no interaction between channels.

Parameters:
- N_BTN, 3, number of button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive mismatching synchronised samples needed to accept a new level (10 ms at 100 MHz); legal minimum is 1.
- REPEAT_DELAY, 50000000, cycles from press pulse to first auto-repeat pulse; used only with BTN_AUTOREPEAT_EN.
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses; used only with BTN_AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous raw button inputs; 1 = pressed.
- btn_level  out  N_BTN  debounced, registered button level.
- btn_pulse  out  N_BTN  one-cycle, registered press strobe; feeds the downstream load enables.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. The polarity and synchronicity are fixed.
- Reset: synchroniser flops, counters, btn_level and btn_pulse all clear to 0 on the first clk edge with rst=1. A reset during an in-progress debounce discards the count.
- Synchroniser: 2-flop chain per channel (s1, s2). Only s2 is used downstream.
- Debounce, per channel: the counter width is clog2(DEBOUNCE_CYCLES+1).
  - On each edge, if s2 == btn_level, the counter goes to 0.
  - Else, if counter == DEBOUNCE_CYCLES-1, btn_level is set to s2 and the counter goes to 0.
  - Otherwise the counter increments.
- Latency: if btn_raw is first sampled 1 at edge k and held, btn_level rises at edge k+1+DEBOUNCE_CYCLES. Release is symmetric.
- Glitches: any mismatch run shorter than DEBOUNCE_CYCLES synchronised samples causes no change, and the counter restarts from 0 on the next match.
- Pulse: btn_pulse[i] is high for exactly the one cycle in which btn_level[i] first reads 1 (registered with btn_level). Release produces no pulse.
- Simultaneous presses on several channels give simultaneous pulses.
- Button held through reset release: btn_level returns to 0 on reset, then rises DEBOUNCE_CYCLES+2 cycles after rst deasserts, with one pulse.
- No combinational path from btn_raw to any output.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: while btn_level[i] stays 1, a per-channel repeat counter runs from the press pulse.
  - An extra one-cycle btn_pulse[i] fires REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
  - The counter clears when btn_level[i] falls or on rst.
- Not defined: exactly one pulse per accepted press. The repeat counters and REPEAT_* parameters synthesise to nothing.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3 overrides):
- rst=1 for 2 cycles with btn_raw=3'b111 -> btn_level=0, btn_pulse=0 during reset. After release, btn_level=3'b111 after 6 cycles, with one pulse on all three channels in that cycle.
- btn_raw[0] 0->1 sampled at edge k and held -> btn_level[0] rises at edge k+5; btn_pulse[0]=1 for that single cycle only; other channels stay 0.
- btn_raw[1] high for 3 cycles then low (glitch) -> btn_level[1] and btn_pulse[1] never assert.
- Chatter pattern 1,0,1,1,1,1,1 on btn_raw[2] -> the counter restarts after the 0; btn_level[2] rises 5 edges after the last 0->1 sample; exactly one pulse.
- Held press released after 20 cycles -> btn_level falls 5 edges after the release sample, with no pulse on release. Without the macro there is a single pulse; with BTN_AUTOREPEAT_EN, pulses come 8 cycles after the first, then every 3 cycles until the level falls.
- Assert rst mid-debounce (counter=2) -> counter and outputs cleared; a fresh 4-sample debounce is required afterwards.
